// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: one outstanding imem request, a single-entry
// output buffer, redirect handling with stale-response discard, and a sticky timeout flag.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    input  logic        redirect,
    input  logic [31:0] branch_pc,
    input  logic [31:0] imm,
    output logic        fetch_err
);

    // state | meaning
    // IDLE  | no request; one-cycle gap before the next fetch issues
    // FETCH | request outstanding, waiting for imem_ack
    // DRAIN | buffer full, waiting for downstream to accept
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    localparam int             CW   = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  TMAX = CW'(TIMEOUT);

    state_t         state, state_nxt;
    logic [31:0]    pc, pc_nxt, target;
    logic           discard, discard_nxt;
    logic [CW-1:0]  wait_cnt, wait_nxt;
    logic           err_nxt;
    logic           load_buf, clear_buf, issue;

    always_comb begin
        target      = (branch_pc + imm) & 32'hFFFF_FFFC;
        state_nxt   = state;
        pc_nxt      = pc;
        discard_nxt = discard;
        wait_nxt    = '0;
        load_buf    = 1'b0;
        clear_buf   = redirect;
        case (state)
            IDLE: begin
                state_nxt = FETCH;
                if (redirect) pc_nxt = target;
            end
            FETCH: begin
                if (imem_ack) begin
                    if (redirect || discard) begin
                        // response belongs to a squashed path; insert one idle cycle
                        state_nxt   = IDLE;
                        discard_nxt = 1'b0;
                        if (redirect) pc_nxt = target;
                    end else begin
                        load_buf  = 1'b1;
                        pc_nxt    = pc + 32'd4;
                        state_nxt = DRAIN;
                    end
                end else begin
                    wait_nxt = (wait_cnt == TMAX) ? wait_cnt : wait_cnt + 1'b1;
                    if (redirect) begin
                        discard_nxt = 1'b1;
                        pc_nxt      = target;
                    end
                end
            end
            DRAIN: begin
                if (redirect) begin
                    pc_nxt    = target;
                    state_nxt = FETCH;
                end else if (instr_valid && instr_ready) begin
                    clear_buf = 1'b1;
                    state_nxt = FETCH;
                end
            end
            default: state_nxt = IDLE;
        endcase
        issue   = (state_nxt == FETCH) && (state != FETCH);
        err_nxt = fetch_err | (wait_nxt == TMAX);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            discard     <= 1'b0;
            wait_cnt    <= '0;
            fetch_err   <= 1'b0;
            imem_req    <= 1'b0;
            imem_addr   <= RESET_PC;
            instr_valid <= 1'b0;
            instr       <= 32'h0;
            instr_pc    <= 32'h0;
        end else begin
            state     <= state_nxt;
            pc        <= pc_nxt;
            discard   <= discard_nxt;
            wait_cnt  <= wait_nxt;
            fetch_err <= err_nxt;
            imem_req  <= (state_nxt == FETCH);
            if (issue) imem_addr <= pc_nxt;
            if (load_buf) begin
                instr_valid <= 1'b1;
                instr       <= imem_rdata;
                instr_pc    <= pc;
            end else if (clear_buf) begin
                instr_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: request-level reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_fetch_sequencer;

    localparam logic [31:0] RPC = 32'h0000_0000;
    localparam int          TO  = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ack = 1'b0;
    logic        ready = 1'b1;
    logic        redirect = 1'b0;
    logic [31:0] rdata = 32'h0;
    logic [31:0] bpc = 32'h0;
    logic [31:0] imm = 32'h0;
    logic        req, valid, err;
    logic [31:0] addr, instr, ipc;

    int vectors = 0;
    int miscompares = 0;

    fetch_sequencer #(.RESET_PC(RPC), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .imem_req(req), .imem_addr(addr), .imem_ack(ack), .imem_rdata(rdata),
        .instr_valid(valid), .instr(instr), .instr_pc(ipc), .instr_ready(ready),
        .redirect(redirect), .branch_pc(bpc), .imm(imm),
        .fetch_err(err)
    );

    always #5 clk = ~clk;

    // Model tracks "is a request outstanding" rather than controller states.
    typedef struct packed {
        logic        out;    // request outstanding
        logic        pend;   // a request must issue at the next edge
        logic        stale;  // outstanding response must be dropped
        logic        valid;
        logic        err;
        logic [31:0] addr;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] ipc;
        logic [7:0]  w;
    } model_t;

    model_t m;

    function automatic model_t model_reset();
        model_t r;
        r = '0;
        r.pend = 1'b1;
        r.addr = RPC;
        r.pc   = RPC;
        return r;
    endfunction

    function automatic model_t model_next(input model_t c, input logic a, input logic [31:0] d,
                                          input logic rd, input logic [31:0] b,
                                          input logic [31:0] im, input logic rdy);
        model_t      n;
        logic [31:0] tgt;
        n   = c;
        tgt = (b + im) & ~32'd3;
        if (c.out) begin
            if (a) begin
                n.out = 1'b0;
                n.w   = 8'd0;
                if (rd || c.stale) begin
                    n.stale = 1'b0;
                    n.pend  = 1'b1;
                    if (rd) n.pc = tgt;
                end else begin
                    n.valid = 1'b1;
                    n.instr = d;
                    n.ipc   = c.addr;
                    n.pc    = c.pc + 32'd4;
                end
            end else begin
                if (int'(c.w) < TO) n.w = c.w + 8'd1;
                if (int'(n.w) == TO) n.err = 1'b1;
                if (rd) begin
                    n.stale = 1'b1;
                    n.pc    = tgt;
                end
            end
        end else begin
            n.w = 8'd0;
            if (rd) begin
                n.valid = 1'b0;
                n.pc    = tgt;
                n.out   = 1'b1;
                n.addr  = tgt;
                n.pend  = 1'b0;
            end else if (c.pend) begin
                n.out  = 1'b1;
                n.addr = c.pc;
                n.pend = 1'b0;
            end else if (c.valid && rdy) begin
                n.valid = 1'b0;
                n.out   = 1'b1;
                n.addr  = c.pc;
            end
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) m <= model_reset();
        else      m <= model_next(m, ack, rdata, redirect, bpc, imm, ready);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("model imem_req", {31'd0, req}, {31'd0, m.out});
        check("model imem_addr", addr, m.addr);
        check("model instr_valid", {31'd0, valid}, {31'd0, m.valid});
        check("model fetch_err", {31'd0, err}, {31'd0, m.err});
        if (m.valid) begin
            check("model instr", instr, m.instr);
            check("model instr_pc", ipc, m.ipc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        ack = 1'b0;
        redirect = 1'b0;
    endtask

    task automatic wait_req();
        int n = 0;
        while (!req && n < 20) begin
            tick();
            n++;
        end
        check("wait for imem_req", {31'd0, req}, 32'd1);
    endtask

    task automatic do_ack(input logic [31:0] d);
        ack = 1'b1;
        rdata = d;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset imem_req", {31'd0, req}, 32'd0);
        check("reset imem_addr", addr, 32'h0);
        check("reset instr_valid", {31'd0, valid}, 32'd0);
        rst = 1'b1;

        // sequential fetch with immediate acceptance
        wait_req(); check("seq addr0", addr, 32'h0);
        do_ack(32'hA000_0000);
        check("seq valid0", {31'd0, valid}, 32'd1);
        check("seq instr0", instr, 32'hA000_0000);
        check("seq ipc0", ipc, 32'h0);
        wait_req(); check("seq addr1", addr, 32'h4);
        do_ack(32'hA000_0004);
        check("seq ipc1", ipc, 32'h4);
        wait_req(); check("seq addr2", addr, 32'h8);
        do_ack(32'hA000_0008);
        check("seq instr2", instr, 32'hA000_0008);
        check("seq ipc2", ipc, 32'h8);
        wait_req(); check("seq addr3", addr, 32'hC);
        do_ack(32'hA000_000C);

        // back-pressure hold
        wait_req(); check("hold addr", addr, 32'h10);
        ready = 1'b0;
        do_ack(32'h0000_0013);
        repeat (5) begin
            tick();
            check("hold req", {31'd0, req}, 32'd0);
            check("hold valid", {31'd0, valid}, 32'd1);
            check("hold instr", instr, 32'h0000_0013);
            check("hold ipc", ipc, 32'h10);
        end
        ready = 1'b1;
        tick();
        check("release req", {31'd0, req}, 32'd1);
        check("release addr", addr, 32'h14);

        // redirect during outstanding fetch
        do_ack(32'hB000_0014);
        wait_req(); check("pre-redir addr18", addr, 32'h18);
        do_ack(32'hB000_0018);
        wait_req(); do_ack(32'hB000_001C);
        wait_req(); check("pre-redir addr20", addr, 32'h20);
        tick(); tick();
        redirect = 1'b1; bpc = 32'h1C; imm = 32'hFFFF_FFF0;
        tick();
        check("redir held req", {31'd0, req}, 32'd1);
        check("redir held addr", addr, 32'h20);
        tick();
        do_ack(32'hDEAD_0020);
        check("dropped valid", {31'd0, valid}, 32'd0);
        check("dropped gap req", {31'd0, req}, 32'd0);
        tick();
        check("redir target req", {31'd0, req}, 32'd1);
        check("redir target addr", addr, 32'h0C);

        // redirect coincident with ack
        redirect = 1'b1; bpc = 32'h100; imm = 32'h7; ack = 1'b1; rdata = 32'hBAD0_000C;
        tick();
        check("coinc valid", {31'd0, valid}, 32'd0);
        check("coinc req", {31'd0, req}, 32'd0);
        tick();
        check("coinc target", addr, 32'h104);

        // double redirect while discarding
        redirect = 1'b1; bpc = 32'h200; imm = 32'h0;
        tick();
        redirect = 1'b1; bpc = 32'h300; imm = 32'h4;
        tick();
        check("discard held addr", addr, 32'h104);
        do_ack(32'hBAD0_0104);
        check("discard valid", {31'd0, valid}, 32'd0);
        tick();
        check("newest target", addr, 32'h304);

        // redirect coincident with transfer in drain
        ready = 1'b0;
        do_ack(32'hC000_0304);
        check("drain ipc", ipc, 32'h304);
        ready = 1'b1; redirect = 1'b1; bpc = 32'h40; imm = 32'h10;
        tick();
        check("drain redir valid", {31'd0, valid}, 32'd0);
        check("drain redir addr", addr, 32'h50);

        // timeout
        repeat (15) tick();
        check("err before timeout", {31'd0, err}, 32'd0);
        tick();
        check("err at timeout", {31'd0, err}, 32'd1);
        check("req during timeout", {31'd0, req}, 32'd1);
        do_ack(32'hD000_0050);
        check("err after ack", {31'd0, err}, 32'd1);
        check("late ack valid", {31'd0, valid}, 32'd1);
        tick(); tick();
        check("err sticky", {31'd0, err}, 32'd1);

        // reset coincident with ack
        wait_req();
        ack = 1'b1; rdata = 32'hE000_0000; rst = 1'b0;
        #1;
        check("rst req", {31'd0, req}, 32'd0);
        check("rst valid", {31'd0, valid}, 32'd0);
        check("rst addr", addr, RPC);
        check("rst err", {31'd0, err}, 32'd0);
        check("rst instr", instr, 32'h0);
        check("rst ipc", ipc, 32'h0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        ack = 1'b0;
        check("post-rst valid", {31'd0, valid}, 32'd0);
        check("post-rst req", {31'd0, req}, 32'd1);
        check("post-rst addr", addr, RPC);
        tick();
        check("post-rst no instr", {31'd0, valid}, 32'd0);
        do_ack(32'hF000_0000);
        check("post-rst instr", instr, 32'hF000_0000);
        check("post-rst ipc", ipc, RPC);
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: fetch address loaded on reset.
REQ-002 Parameter TIMEOUT, default 16: maximum cycles an imem request may wait for ack before an error is raised.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-low: assertion (0) resets immediately; release is sampled at a rising clk edge.
REQ-005 imem_req  output  1  instruction-memory request, registered.
REQ-006 imem_addr  output  32  request address, registered; equals the internal PC.
REQ-007 imem_ack  input  1  one-cycle response strobe; imem_rdata is valid in the same cycle.
REQ-008 imem_rdata  input  32  fetched instruction word.
REQ-009 instr_valid  output  1  output buffer holds an instruction.
REQ-010 instr  output  32  buffered instruction word.
REQ-011 instr_pc  output  32  address the buffered instruction was fetched from.
REQ-012 instr_ready  input  1  downstream accepts; a transfer occurs when instr_valid && instr_ready.
REQ-013 redirect  input  1  taken branch/jump; one-cycle pulse.
REQ-014 branch_pc  input  32  PC of the redirecting instruction.
REQ-015 imm  input  32  sign-extended branch offset.
REQ-016 fetch_err  output  1  sticky timeout flag.

Function
REQ-017 States: IDLE, FETCH, DRAIN; at most one imem request outstanding at any time.
REQ-018 IDLE: imem_req=0; next cycle -> FETCH.
REQ-019 FETCH: imem_req=1, imem_addr=PC; imem_req and imem_addr are held stable until the cycle imem_ack=1.
REQ-020 FETCH with ack, no redirect, discard=0: buffer loads instr=imem_rdata and instr_pc=PC; instr_valid=1 next cycle; PC<=PC+4 (mod 2^32); -> DRAIN; imem_req=0 next cycle.
REQ-021 DRAIN: imem_req=0; on instr_valid && instr_ready, the buffer empties (instr_valid=0 next cycle) and the state -> FETCH; otherwise the buffer holds its values.
REQ-022 Redirect target = (branch_pc + imm) mod 2^32 with bits[1:0] forced to 0; on redirect, PC<=target and the buffer is cleared (instr_valid=0 next cycle), in every state.
REQ-023 Redirect in IDLE or DRAIN: -> FETCH; the first request issues next cycle at the target address.
REQ-024 Redirect in FETCH without ack in the same cycle: discard<=1; the request stays asserted at the old address until ack.
REQ-025 FETCH ack with discard=1: response dropped (buffer not loaded, PC unchanged); discard<=0; imem_req deasserts for one cycle, then reissues at the new PC.
REQ-026 Redirect and ack in the same FETCH cycle: response dropped; discard stays 0; next request at the target after one idle cycle.
REQ-027 Redirect while discard=1: PC updates to the newest target; discard stays 1.
REQ-028 Redirect coincident with a transfer (instr_valid && instr_ready): the transfer counts as accepted; the buffer clears.
REQ-029 Wait counter: cleared on every cycle not in FETCH and on ack; increments each FETCH cycle without ack; saturates at TIMEOUT.
REQ-030 When the wait counter reaches TIMEOUT, fetch_err<=1 (sticky until reset); the request remains asserted.
REQ-031 instr, instr_pc and instr_valid change only per REQ-020, REQ-021, REQ-022 and REQ-028.

Reset
REQ-032 While rst=0: state=IDLE, PC=RESET_PC, imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0, discard=0, wait counter=0, fetch_err=0.
REQ-033 Reset mid-request abandons the outstanding request; an ack arriving while rst=0, or in the first cycle after release, is ignored.

Verification
REQ-034 Reset release with RESET_PC=0, ack one cycle after each req, instr_ready=1 -> imem_addr sequence 0x0, 0x4, 0x8; instr_pc matches each; instr equals the supplied rdata.
REQ-035 Buffer holding 0x0000_0013 at instr_pc=0x10 with instr_ready=0 for 5 cycles -> imem_req=0 and the buffer is stable throughout; instr_ready=1 -> next request at 0x14.
REQ-036 Redirect during an outstanding FETCH at 0x20 with branch_pc=0x1C, imm=0xFFFF_FFF0 -> old ack dropped, no instr_valid; next imem_addr=0x0C.
REQ-037 Redirect and ack in the same cycle with branch_pc=0x100, imm=0x7 -> response dropped; next imem_addr=0x104 (low bits cleared).
REQ-038 ack withheld for TIMEOUT=16 FETCH cycles -> fetch_err=1 from the 16th cycle onward and remains 1 after a later ack; clears only on rst=0.
REQ-039 rst=0 asserted in the same cycle as imem_ack -> all outputs at their reset values immediately; no instr_valid after release until a new request completes.
